// File: rtl/rf_pkg.sv
// Shared defaults for the hazard-tracking register file and its pending-write scoreboard.
// Optional same-cycle write bypass is selected with the RF_BYPASS_EN macro.
package rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 15;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_NUM_RD   = 2;
  localparam int RF_CNT_W    = 2;

  typedef logic [RF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters: busy flags, allocation back-pressure and underflow detection.
// With RF_BYPASS_EN defined, read busy flags reflect a same-cycle writeback.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int CNT_W    = RF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     alloc_stall,
  output logic                     err_underflow
);

  localparam logic [ADDR_W:0]  LIMIT   = (ADDR_W+1)'(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic             wr_valid;
  logic             alloc_valid;
  logic             alloc_ok;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] alloc_cnt;

  assign wr_valid    = wr_en && ({1'b0, wr_addr} < LIMIT);
  assign alloc_valid = alloc_en && ({1'b0, alloc_addr} < LIMIT);
  assign wr_cnt      = wr_valid ? cnt[wr_addr] : '0;
  assign alloc_cnt   = alloc_valid ? cnt[alloc_addr] : '0;

  // Handshake: alloc_en is the request (valid) and !alloc_stall is the grant (ready);
  // a reservation is taken only on a rising edge where alloc_en=1 and alloc_stall=0.
  // A same-cycle writeback to a saturated register frees the slot it would need.
  assign alloc_stall = alloc_valid && (alloc_cnt == CNT_MAX) &&
                       !(wr_valid && (wr_addr == alloc_addr));
  assign alloc_ok    = alloc_valid && !alloc_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (wr_valid && (wr_cnt == '0)) err_underflow <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (alloc_ok && (alloc_addr == ADDR_W'(i)) &&
            !(wr_valid && (wr_addr == ADDR_W'(i)))) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (wr_valid && (wr_addr == ADDR_W'(i)) &&
                     !(alloc_ok && (alloc_addr == ADDR_W'(i))) &&
                     (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_busy
    logic [ADDR_W-1:0] a;
    logic [CNT_W-1:0]  c;
    assign a = rd_addr[g*ADDR_W +: ADDR_W];
    assign c = ({1'b0, a} < LIMIT) ? cnt[a] : '0;
`ifdef RF_BYPASS_EN
    // Post-decrement view: a count of 1 being retired this cycle reads as free.
    assign rd_busy[g] = (wr_valid && (wr_addr == a)) ? (c > CNT_W'(1)) : (c != '0);
`else
    assign rd_busy[g] = (c != '0);
`endif
  end

endmodule

// File: rtl/hazard_register_file.sv
// Register file with per-register pending-write tracking for an in-order issue stage.
// Define RF_BYPASS_EN to forward a same-cycle writeback to matching read ports.
module hazard_register_file
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int CNT_W    = RF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     alloc_stall,
  output logic                     err_underflow
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_valid;

  assign wr_valid = wr_en && ({1'b0, wr_addr} < LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_valid) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] stored;
    assign a      = rd_addr[g*ADDR_W +: ADDR_W];
    assign stored = ({1'b0, a} < LIMIT) ? regs[a] : '0;
`ifdef RF_BYPASS_EN
    assign rd_data[g*DATA_W +: DATA_W] = (wr_valid && (wr_addr == a)) ? wr_data : stored;
`else
    assign rd_data[g*DATA_W +: DATA_W] = stored;
`endif
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .rd_addr       (rd_addr),
    .rd_busy       (rd_busy),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .alloc_en      (alloc_en),
    .alloc_addr    (alloc_addr),
    .alloc_stall   (alloc_stall),
    .err_underflow (err_underflow)
  );

endmodule

// File: tb/tb_hazard_register_file.sv
// Randomized and directed bench for hazard_register_file against an array-based reference model.
// Build with RF_BYPASS_EN defined to check the same-cycle forwarding variant.
module tb_hazard_register_file;

  localparam int DW   = 32;
  localparam int NR   = 15;
  localparam int AW   = 4;
  localparam int ND   = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int EW   = ND*DW + ND + 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [ND*AW-1:0] rd_addr;
  logic [ND*DW-1:0] rd_data;
  logic [ND-1:0]    rd_busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             alloc_stall;
  logic             err_underflow;

  hazard_register_file #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(ND), .CNT_W(CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_busy       (rd_busy),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .alloc_en      (alloc_en),
    .alloc_addr    (alloc_addr),
    .alloc_stall   (alloc_stall),
    .err_underflow (err_underflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: architectural view of the register file
  logic [DW-1:0]   m_reg [NR];
  int              m_cnt [NR];
  bit              m_err;
  logic [EW-1:0]   exp_q [$];
  int              total = 0;
  int              bad   = 0;

  function automatic void model_clear();
    for (int i = 0; i < NR; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic bit model_stall(bit we, int wa, bit ae, int aa);
    if (!ae || aa >= NR) return 1'b0;
    return (m_cnt[aa] == CMAX) && !(we && wa < NR && wa == aa);
  endfunction

  function automatic logic [EW-1:0] model_out(bit we, int wa, logic [DW-1:0] wd,
                                              bit ae, int aa, int r0, int r1);
    logic [DW-1:0] d [ND];
    logic [ND-1:0] b;
    for (int p = 0; p < ND; p++) begin
      int a;
      a    = (p == 0) ? r0 : r1;
      d[p] = '0;
      b[p] = 1'b0;
      if (a < NR) begin
        d[p] = m_reg[a];
        b[p] = (m_cnt[a] != 0);
`ifdef RF_BYPASS_EN
        if (we && wa < NR && wa == a) begin
          d[p] = wd;
          b[p] = (m_cnt[a] > 1);
        end
`endif
      end
    end
    return {d[1], d[0], b, model_stall(we, wa, ae, aa), m_err};
  endfunction

  function automatic void model_edge(bit we, int wa, logic [DW-1:0] wd, bit ae, int aa);
    bit wv, av;
    wv = we && (wa < NR);
    av = ae && (aa < NR) && !model_stall(we, wa, ae, aa);
    if (wv) begin
      if (m_cnt[wa] == 0) m_err = 1'b1;
      m_reg[wa] = wd;
    end
    if (!(av && wv && aa == wa)) begin
      if (av) m_cnt[aa] = m_cnt[aa] + 1;
      if (wv && m_cnt[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
    end
  endfunction

  // driver: apply one cycle of stimulus, log expected outputs, advance the model at the edge
  task automatic step(bit rst, bit we, int wa, logic [DW-1:0] wd, bit ae, int aa, int r0, int r1);
    reset      = rst;
    wr_en      = we;
    wr_addr    = AW'(wa);
    wr_data    = wd;
    alloc_en   = ae;
    alloc_addr = AW'(aa);
    rd_addr    = {AW'(r1), AW'(r0)};
    if (rst) model_clear();
    exp_q.push_back(model_out(we, wa, wd, ae, aa, r0, r1));
    @(posedge clk);
    if (!rst) model_edge(we, wa, wd, ae, aa);
    #1;
  endtask

  task automatic idle_read(int r0, int r1);
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, r0, r1);
  endtask

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // monitor: sample mid-cycle and compare against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("rd_data0",      rd_data[DW-1:0],        e[DW+ND+1 : ND+2]);
      check("rd_data1",      rd_data[2*DW-1:DW],     e[EW-1 -: DW]);
      check("rd_busy",       DW'(rd_busy),           DW'(e[ND+1:2]));
      check("alloc_stall",   DW'(alloc_stall),       DW'(e[1]));
      check("err_underflow", DW'(err_underflow),     DW'(e[0]));
    end
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;
    model_clear();
    @(posedge clk); #1;

    // reset, with strobes that must be ignored
    step(1'b1, 1'b1, 2, 32'h1234_5678, 1'b1, 2, 2, 2);
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 0, 0);
    for (int i = 0; i < NR; i++) idle_read(i, NR - 1 - i);

    // write R3 while reading it, then read again
    step(1'b0, 1'b1, 3, 32'hDEAD_BEEF, 1'b0, 0, 3, 3);
    idle_read(3, 3);

    // saturate R5, stalled alloc, alloc concurrent with writeback
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, '0, 1'b1, 5, 5, 3);
    step(1'b0, 1'b0, 0, '0, 1'b1, 5, 5, 5);
    step(1'b0, 1'b1, 5, 32'h0000_0055, 1'b1, 5, 5, 5);
    idle_read(5, 5);

    // drain R5 then underflow it
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5, 32'hA5A5_0000 + i, 1'b0, 0, 5, 0);
    idle_read(5, 5);
    step(1'b0, 1'b1, 5, 32'hCAFE_F00D, 1'b0, 0, 5, 5);
    idle_read(5, 3);
    idle_read(5, 3);

    // out-of-range register
    step(1'b0, 1'b1, 15, 32'hFFFF_FFFF, 1'b0, 0, 15, 15);
    step(1'b0, 1'b0, 0, '0, 1'b1, 15, 15, 0);
    idle_read(15, 15);

    // reset between alloc and writeback of R7
    step(1'b0, 1'b1, 7, 32'h7777_7777, 1'b0, 0, 7, 7);
    step(1'b0, 1'b0, 0, '0, 1'b1, 7, 7, 7);
    step(1'b0, 1'b0, 0, '0, 1'b1, 7, 7, 7);
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 7, 5);
    idle_read(7, 7);
    step(1'b0, 1'b1, 7, 32'h0BAD_0007, 1'b0, 0, 7, 7);
    idle_read(7, 7);

    // randomized traffic concentrated on a few registers to reach saturation
    for (int n = 0; n < 800; n++) begin
      bit rst, we, ae;
      int wa, aa, r0, r1;
      rst = ($urandom_range(0, 149) == 0);
      we  = ($urandom_range(0, 2) == 0);
      ae  = ($urandom_range(0, 1) == 0);
      wa  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      aa  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      r0  = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 15));
      r1  = ($urandom_range(0, 2) == 0) ? aa : int'($urandom_range(0, 15));
      step(rst, we, wa, $urandom, ae, aa, r0, r1);
    end

    idle_read(0, 1);
    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_register_file.md
HAZARD_REGISTER_FILE -- requirements
Module: hazard_register_file

Interface
REQ-001 Parameter DATA_W, 32, register width in bits.
REQ-002 Parameter NUM_REGS, 15, number of architectural registers.
REQ-003 Parameter ADDR_W, 4, register address width; SHALL satisfy 2**ADDR_W >= NUM_REGS.
REQ-004 Parameter NUM_RD, 2, number of read ports.
REQ-005 Parameter CNT_W, 2, width of each per-register pending-write counter.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 reset  in  1  reset, asynchronous, active-high.
REQ-008 rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 rd_data  out  NUM_RD*DATA_W  packed read data, same packing as rd_addr.
REQ-010 rd_busy  out  NUM_RD  per-port flag: the addressed register has pending writes.
REQ-011 wr_en  in  1  writeback strobe.
REQ-012 wr_addr  in  ADDR_W  writeback destination.
REQ-013 wr_data  in  DATA_W  writeback value.
REQ-014 alloc_en  in  1  issue stage reserves a destination register.
REQ-015 alloc_addr  in  ADDR_W  register being reserved.
REQ-016 alloc_stall  out  1  allocation refused this cycle.
REQ-017 err_underflow  out  1  sticky flag: writeback to a register with zero pending count.

Function
REQ-018 Reads SHALL be combinational: rd_data port i = register[rd_addr i]; an address >= NUM_REGS SHALL read as 0 with rd_busy 0.
REQ-019 When wr_en=1 and wr_addr < NUM_REGS, register[wr_addr] SHALL take wr_data on the rising edge; wr_addr >= NUM_REGS SHALL be ignored with no state change.
REQ-020 Each register SHALL own a CNT_W-bit pending counter; rd_busy i = (counter[rd_addr i] != 0).
REQ-021 Accepted alloc (alloc_en=1, valid address, alloc_stall=0) SHALL increment the counter by 1 at the rising edge.
REQ-022 Valid writeback SHALL decrement the counter of wr_addr by 1 at the rising edge.
REQ-023 Accepted alloc and valid writeback to the same address in one cycle SHALL leave that counter unchanged; to different addresses, both updates SHALL apply.
REQ-024 alloc_stall SHALL be combinational: 1 when alloc_en=1 and counter[alloc_addr] = 2**CNT_W-1 and no same-cycle valid writeback to alloc_addr; otherwise 0. A stalled alloc SHALL change no state.
REQ-025 alloc to an address >= NUM_REGS SHALL be ignored with alloc_stall 0.
REQ-026 Valid writeback to a register with counter 0 SHALL still write data, leave the counter at 0, and set err_underflow to 1 until reset.
REQ-027 Counters SHALL never wrap in either direction.

Reset
REQ-028 While reset=1: all registers SHALL be 0, all counters 0, err_underflow 0, asynchronously and independent of clk.
REQ-029 After reset deasserts, rd_data SHALL be all 0, rd_busy all 0, alloc_stall 0.
REQ-030 wr_en or alloc_en asserted during reset SHALL have no effect; the block SHALL require no file-based initial contents.

Configuration
REQ-031 Macro RF_BYPASS_EN defined: when wr_en=1 with a valid wr_addr equal to rd_addr i, rd_data i SHALL equal wr_data in the same cycle, and rd_busy i SHALL reflect the post-decrement count.
REQ-032 RF_BYPASS_EN undefined: rd_data and rd_busy SHALL reflect only stored state; the new value SHALL be visible from the cycle after the write.

Structure
REQ-033 Package rf_pkg SHALL hold the default DATA_W, NUM_REGS, ADDR_W, NUM_RD and CNT_W constants and the counter typedef.
REQ-034 Counter logic (REQ-020 to REQ-027) SHALL be a sub-module rf_scoreboard; data storage and read muxing SHALL stay in hazard_register_file.

Verification
REQ-035 Reset, then read R0..R14 on both ports -> all rd_data 0, rd_busy 0, err_underflow 0.
REQ-036 Write R3=0xDEADBEEF while reading R3 -> with RF_BYPASS_EN, 0xDEADBEEF in the same cycle; without it, 0 that cycle and 0xDEADBEEF the next.
REQ-037 Alloc R5 three times -> rd_busy 1; a fourth alloc -> alloc_stall 1 and count stays 3; same-cycle alloc plus write R5 -> no stall, count 3.
REQ-038 Three writebacks to R5 -> count 0, rd_busy 0; a fourth writeback -> data written, err_underflow 1 and it persists.
REQ-039 Write R15 and read R15 -> no state change, rd_data 0; alloc R15 -> ignored, alloc_stall 0.
REQ-040 Assert reset between alloc and writeback of R7 -> counter and data 0 immediately without a clock edge; a later writeback to R7 sets err_underflow.
